// File: rtl/wash_phase_timer_if.sv
// Control-FSM <-> phase-timer connection: run/phase/mode/lid requests in,
// done/remaining/status back out.
interface wash_phase_timer_if #(
    parameter int CNT_W = 8
);
    logic             timer_enable;
    logic [1:0]       phase_sel;
    logic             mode1;
    logic             mode2;
    logic             mode3;
    logic             lid;
    logic             timer_done;
    logic [CNT_W-1:0] remaining;
    logic             busy;
    logic             paused;

    // Control FSM side
    modport master (
        output timer_enable, phase_sel, mode1, mode2, mode3, lid,
        input  timer_done, remaining, busy, paused
    );

    // Timer side
    modport slave (
        input  timer_enable, phase_sel, mode1, mode2, mode3, lid,
        output timer_done, remaining, busy, paused
    );
endinterface

// File: rtl/wash_phase_timer.sv
// Phase timer/sequencer for the washing-machine controller. Loads a
// mode-scaled duration for the selected phase, counts it down in prescaled
// ticks, freezes while the lid is open and raises timer_done when elapsed.
module wash_phase_timer #(
    parameter int CNT_W    = 8,
    parameter int TICK_DIV = 1000,
    parameter int SOAK_T   = 4,
    parameter int WASH_T   = 8,
    parameter int RINSE_T  = 6,
    parameter int SPIN_T   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wash_phase_timer_if.slave    bus
);
    // TICK_DIV may be as large as 2^16, so the prescaler needs 16 bits to
    // reach a terminal count of TICK_DIV-1.
    localparam int PRE_W = 16;
    localparam int DW    = CNT_W + 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COUNT,
        PAUSE,
        HOLD
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic [PRE_W-1:0] pre_reg, pre_next;
    logic [1:0]       mode_reg, mode_next;
    logic [1:0]       phase_reg, phase_next;

    logic [1:0]       mode_in;
    logic [DW-1:0]    base_w;
    logic [DW-1:0]    scaled_w;
    logic [CNT_W-1:0] duration;
    logic             phase_changed;

    // Mode priority encode (mode3 highest) and duration for the current phase.
    always_comb begin
        mode_in  = 2'd0;
        base_w   = '0;
        scaled_w = '0;
        duration = '0;

        if (bus.mode3) begin
            mode_in = 2'd3;
        end else if (bus.mode2) begin
            mode_in = 2'd2;
        end else if (bus.mode1) begin
            mode_in = 2'd1;
        end

        case (bus.phase_sel)
            2'b00:   base_w = DW'(SOAK_T);
            2'b01:   base_w = DW'(WASH_T);
            2'b10:   base_w = DW'(RINSE_T);
            default: base_w = DW'(SPIN_T);
        endcase

        case (mode_reg)
            2'd3:    scaled_w = base_w << 1;
            2'd2:    scaled_w = base_w + (base_w >> 1);
            default: scaled_w = base_w;
        endcase

        // Top bit set means the result exceeds the counter range; a zero
        // duration is stretched to one tick so the phase still completes.
        if (scaled_w[CNT_W]) begin
            duration = '1;
        end else if (scaled_w[CNT_W-1:0] == '0) begin
            duration = CNT_W'(1);
        end else begin
            duration = scaled_w[CNT_W-1:0];
        end
    end

    assign phase_changed = (bus.phase_sel != phase_reg);

    // Next-state and datapath update; enable drop beats phase change beats lid.
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        pre_next       = pre_reg;
        mode_next      = mode_reg;
        phase_next     = phase_reg;

        case (state_reg)
            IDLE: begin
                if (bus.timer_enable) begin
                    state_next = LOAD;
                    mode_next  = mode_in;
                end
            end

            LOAD: begin
                phase_next = bus.phase_sel;
                if (!bus.timer_enable) begin
                    state_next     = IDLE;
                    remaining_next = '0;
                    pre_next       = '0;
                end else begin
                    state_next     = COUNT;
                    remaining_next = duration;
                    pre_next       = '0;
                end
            end

            COUNT: begin
                if (!bus.timer_enable) begin
                    state_next     = IDLE;
                    remaining_next = '0;
                    pre_next       = '0;
                end else if (phase_changed) begin
                    state_next = LOAD;
                end else if (bus.lid) begin
                    state_next = PAUSE;
                end else if (pre_reg == PRE_LAST) begin
                    pre_next       = '0;
                    remaining_next = remaining_reg - CNT_W'(1);
                    if (remaining_reg == CNT_W'(1)) begin
                        state_next = HOLD;
                    end
                end else begin
                    pre_next = pre_reg + PRE_W'(1);
                end
            end

            PAUSE: begin
                if (!bus.timer_enable) begin
                    state_next     = IDLE;
                    remaining_next = '0;
                    pre_next       = '0;
                end else if (!bus.lid) begin
                    state_next = COUNT;
                end
            end

            HOLD: begin
                if (!bus.timer_enable) begin
                    state_next     = IDLE;
                    remaining_next = '0;
                    pre_next       = '0;
                end else if (phase_changed) begin
                    state_next = LOAD;
                end
            end

            default: begin
                state_next     = IDLE;
                remaining_next = '0;
                pre_next       = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            pre_reg       <= '0;
            mode_reg      <= 2'd0;
            phase_reg     <= 2'd0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            pre_reg       <= pre_next;
            mode_reg      <= mode_next;
            phase_reg     <= phase_next;
        end
    end

    // Status decoded from registered state; only timer_done sees the lid.
    assign bus.remaining  = remaining_reg;
    assign bus.busy       = (state_reg != IDLE);
    assign bus.paused     = (state_reg == PAUSE);
    assign bus.timer_done = (state_reg == HOLD) & ~bus.lid;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Testbench for wash_phase_timer: three instances with different parameter
// sets share one stimulus stream; directed scenarios plus randomized runs
// checked against duration/latency rules computed arithmetically.
module tb_wash_phase_timer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] ph = 2'b00;
    logic       m1 = 1'b0;
    logic       m2 = 1'b0;
    logic       m3 = 1'b0;
    logic       lid = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wash_phase_timer_if #(.CNT_W(8)) ifa ();
    wash_phase_timer_if #(.CNT_W(8)) ifb ();
    wash_phase_timer_if #(.CNT_W(4)) ifc ();

    assign ifa.timer_enable = en;  assign ifa.phase_sel = ph;
    assign ifa.mode1 = m1; assign ifa.mode2 = m2; assign ifa.mode3 = m3; assign ifa.lid = lid;
    assign ifb.timer_enable = en;  assign ifb.phase_sel = ph;
    assign ifb.mode1 = m1; assign ifb.mode2 = m2; assign ifb.mode3 = m3; assign ifb.lid = lid;
    assign ifc.timer_enable = en;  assign ifc.phase_sel = ph;
    assign ifc.mode1 = m1; assign ifc.mode2 = m2; assign ifc.mode3 = m3; assign ifc.lid = lid;

    wash_phase_timer #(.CNT_W(8), .TICK_DIV(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    wash_phase_timer #(.CNT_W(8), .TICK_DIV(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    wash_phase_timer #(.CNT_W(4), .TICK_DIV(1), .WASH_T(12), .SPIN_T(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    // Reference: mode code from priority, duration from base and scaling rule.
    function automatic int mode_code(logic a1, logic a2, logic a3);
        if (a3) return 3;
        if (a2) return 2;
        if (a1) return 1;
        return 0;
    endfunction

    function automatic int dur(int base, int code, int cw);
        int d;
        if (code == 3) d = base * 2;
        else if (code == 2) d = base + base / 2;
        else d = base;
        if (d > (1 << cw) - 1) d = (1 << cw) - 1;
        if (d == 0) d = 1;
        return d;
    endfunction

    function automatic int base_std(int p);
        case (p)
            0: return 4;
            1: return 8;
            2: return 6;
            default: return 5;
        endcase
    endfunction

    function automatic int base_c(int p);
        case (p)
            0: return 4;
            1: return 12;
            2: return 6;
            default: return 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap();
        en = 1'b0; lid = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (ifa.busy !== 1'b0 || ifa.remaining !== 8'd0 || ifa.timer_done !== 1'b0 || ifa.paused !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial busy=%b rem=%0d done=%b paused=%b required 0", ifa.busy, ifa.remaining, ifa.timer_done, ifa.paused);
        end
        tick(); rst_n = 1'b1; tick();
        en = 1'b1; m1 = 1'b1; ph = 2'b00;
        tick(); tick(); tick(); tick();
        checks++;
        if (ifb.busy !== 1'b1 || ifb.remaining !== 8'd4) begin
            errors++;
            $display("FAIL reset_precount busy=%b rem=%0d required busy=1 rem=4", ifb.busy, ifb.remaining);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (ifb.busy !== 1'b0 || ifb.remaining !== 8'd0 || ifa.timer_done !== 1'b0 || ifa.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async b.busy=%b b.rem=%0d a.done=%b a.busy=%b required 0", ifb.busy, ifb.remaining, ifa.timer_done, ifa.busy);
        end
        en = 1'b0;
        tick(); rst_n = 1'b1; tick(); tick();
        checks++;
        if (ifa.busy !== 1'b0 || ifb.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle a.busy=%b b.busy=%b required 0", ifa.busy, ifb.busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_soak();
        m1 = 1'b1; m2 = 1'b0; m3 = 1'b0; ph = 2'b00; lid = 1'b0; en = 1'b1;
        tick();  // edge 0
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (ifa.remaining !== 8'(5 - i) || ifa.timer_done !== (i == 5)) begin
                errors++;
                $display("FAIL soak_edge%0d rem=%0d done=%b required rem=%0d done=%b", i, ifa.remaining, ifa.timer_done, 5 - i, (i == 5));
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ifa.timer_done !== 1'b1) begin
                errors++;
                $display("FAIL soak_done_hold cycle=%0d done=%b required 1", i, ifa.timer_done);
            end
        end
        ph = 2'b01;
        tick();
        checks++;
        if (ifa.timer_done !== 1'b0) begin
            errors++;
            $display("FAIL soak_done_fall done=%b required 0", ifa.timer_done);
        end
        tick();
        checks++;
        if (ifa.remaining !== 8'd8) begin
            errors++;
            $display("FAIL soak_next_load rem=%0d required 8", ifa.remaining);
        end
        idle_gap();
        $display("test_soak done");
    endtask

    task automatic test_mode_scaling();
        m1 = 1'b0; m2 = 1'b1; m3 = 1'b1; ph = 2'b01; en = 1'b1;
        tick(); tick();
        checks++;
        if (ifa.remaining !== 8'd16) begin
            errors++;
            $display("FAIL mode3_wash rem=%0d required 16", ifa.remaining);
        end
        idle_gap();
        m3 = 1'b0; ph = 2'b10; en = 1'b1;
        tick(); tick();
        checks++;
        if (ifa.remaining !== 8'd9) begin
            errors++;
            $display("FAIL mode2_rinse rem=%0d required 9", ifa.remaining);
        end
        m1 = 1'b1; m2 = 1'b0;
        tick();
        ph = 2'b11;
        tick(); tick();
        checks++;
        if (ifa.remaining !== 8'd7) begin
            errors++;
            $display("FAIL mode2_spin_after_toggle rem=%0d required 7", ifa.remaining);
        end
        idle_gap();
        m1 = 1'b0;
        $display("test_mode_scaling done");
    endtask

    task automatic test_lid_pause();
        int n;
        bit ok;
        m1 = 1'b1; ph = 2'b01; en = 1'b1;
        ok = 1'b0;
        for (n = 0; n < 100 && !ok; n++) begin
            tick();
            if (ifb.remaining == 8'd5) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL lid_wait_rem5 rem=%0d required 5 within 100 cycles", ifb.remaining);
        end
        tick();  // one prescale step into the tick
        lid = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (ifb.paused !== 1'b1 || ifb.remaining !== 8'd5) begin
                errors++;
                $display("FAIL lid_frozen cycle=%0d paused=%b rem=%0d required paused=1 rem=5", i, ifb.paused, ifb.remaining);
            end
            tick();
        end
        lid = 1'b0;
        tick();
        checks++;
        if (ifb.paused !== 1'b0 || ifb.remaining !== 8'd5) begin
            errors++;
            $display("FAIL lid_resume paused=%b rem=%0d required paused=0 rem=5", ifb.paused, ifb.remaining);
        end
        tick();
        checks++;
        if (ifb.remaining !== 8'd5) begin
            errors++;
            $display("FAIL lid_resume_prescale rem=%0d required 5", ifb.remaining);
        end
        tick();
        checks++;
        if (ifb.remaining !== 8'd4) begin
            errors++;
            $display("FAIL lid_first_decrement rem=%0d required 4", ifb.remaining);
        end
        ok = 1'b0;
        for (n = 0; n < 50 && !ok; n++) begin
            tick();
            if (ifb.timer_done === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL lid_wait_done done=%b required 1 within 50 cycles", ifb.timer_done);
        end
        lid = 1'b1;
        #1;
        checks++;
        if (ifb.timer_done !== 1'b0) begin
            errors++;
            $display("FAIL lid_hold_gate done=%b required 0", ifb.timer_done);
        end
        tick();
        checks++;
        if (ifb.timer_done !== 1'b0 || ifb.busy !== 1'b1) begin
            errors++;
            $display("FAIL lid_hold_stay done=%b busy=%b required done=0 busy=1", ifb.timer_done, ifb.busy);
        end
        lid = 1'b0;
        #1;
        checks++;
        if (ifb.timer_done !== 1'b1) begin
            errors++;
            $display("FAIL lid_hold_release done=%b required 1", ifb.timer_done);
        end
        idle_gap();
        m1 = 1'b0;
        $display("test_lid_pause done");
    endtask

    task automatic test_cancel();
        bit ok;
        m1 = 1'b1; ph = 2'b01; en = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            tick();
            if (ifa.remaining == 8'd3) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cancel_wait_rem3 rem=%0d required 3 within 40 cycles", ifa.remaining);
        end
        en = 1'b0;
        tick();
        checks++;
        if (ifa.remaining !== 8'd0 || ifa.busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_clear rem=%0d busy=%b required rem=0 busy=0", ifa.remaining, ifa.busy);
        end
        m1 = 1'b0; m3 = 1'b1; en = 1'b1;
        tick(); tick();
        checks++;
        if (ifa.remaining !== 8'd16) begin
            errors++;
            $display("FAIL cancel_fresh_latch rem=%0d required 16", ifa.remaining);
        end
        idle_gap();
        m3 = 1'b0;
        $display("test_cancel done");
    endtask

    task automatic test_saturation();
        m3 = 1'b1; ph = 2'b01; en = 1'b1;
        tick(); tick();
        checks++;
        if (ifc.remaining !== 4'd15) begin
            errors++;
            $display("FAIL sat_wash rem=%0d required 15", ifc.remaining);
        end
        idle_gap();
        m3 = 1'b0; m1 = 1'b1; ph = 2'b11; en = 1'b1;
        tick(); tick();
        checks++;
        if (ifc.remaining !== 4'd1 || ifc.timer_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_spin_load rem=%0d done=%b required rem=1 done=0", ifc.remaining, ifc.timer_done);
        end
        tick();
        checks++;
        if (ifc.remaining !== 4'd0 || ifc.timer_done !== 1'b1) begin
            errors++;
            $display("FAIL zero_spin_done rem=%0d done=%b required rem=0 done=1", ifc.remaining, ifc.timer_done);
        end
        idle_gap();
        m1 = 1'b0;
        $display("test_saturation done");
    endtask

    // Random runs: done must appear at edge 1 + D*TICK_DIV, plus L+1 edges
    // when the lid is held for L sampled edges during counting.
    task automatic test_random();
        int code, p, da, db, dc, len, s, wmax, ea, eb, ec, lim;
        int got_a, got_b, got_c;
        for (int it = 0; it < 20; it++) begin
            m1 = 1'($urandom_range(0, 1));
            m2 = 1'($urandom_range(0, 1));
            m3 = 1'($urandom_range(0, 1));
            p = int'($urandom_range(0, 3));
            ph = 2'(p);
            code = mode_code(m1, m2, m3);
            da = dur(base_std(p), code, 8);
            db = dur(base_std(p), code, 8);
            dc = dur(base_c(p), code, 4);
            wmax = da;
            if (db * 3 < wmax) wmax = db * 3;
            if (dc < wmax) wmax = dc;
            wmax = wmax + 1;
            len = int'($urandom_range(0, 4));
            s = int'($urandom_range(2, wmax));
            ea = 1 + da + ((len > 0) ? len + 1 : 0);
            eb = 1 + db * 3 + ((len > 0) ? len + 1 : 0);
            ec = 1 + dc + ((len > 0) ? len + 1 : 0);
            lim = ea;
            if (eb > lim) lim = eb;
            if (ec > lim) lim = ec;
            lim = lim + 3;
            got_a = -1; got_b = -1; got_c = -1;
            en = 1'b1;
            for (int e = 0; e <= lim; e++) begin
                lid = (len > 0 && e >= s && e < s + len);
                tick();
                if (e == 1) begin
                    checks++;
                    if (ifa.remaining !== 8'(da) || ifb.remaining !== 8'(db) || ifc.remaining !== 4'(dc)) begin
                        errors++;
                        $display("FAIL rand%0d_load rem a/b/c=%0d/%0d/%0d required %0d/%0d/%0d", it, ifa.remaining, ifb.remaining, ifc.remaining, da, db, dc);
                    end
                end
                if (got_a < 0 && ifa.timer_done === 1'b1) got_a = e;
                if (got_b < 0 && ifb.timer_done === 1'b1) got_b = e;
                if (got_c < 0 && ifc.timer_done === 1'b1) got_c = e;
            end
            checks++;
            if (got_a != ea || got_b != eb || got_c != ec) begin
                errors++;
                $display("FAIL rand%0d_done_edge a/b/c=%0d/%0d/%0d required %0d/%0d/%0d", it, got_a, got_b, got_c, ea, eb, ec);
            end
            $display("rand %0d: phase=%0d mode=%0d lid_len=%0d D=%0d/%0d/%0d done edges %0d/%0d/%0d", it, p, code, len, da, db, dc, got_a, got_b, got_c);
            idle_gap();
        end
        m1 = 1'b0; m2 = 1'b0; m3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_soak();
        test_mode_scaling();
        test_lid_pause();
        test_cancel();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation still running at 2ms required completion");
        $fatal(1, "timeout");
    end
endmodule
